// File: rtl/fetch_prefetch_queue_pkg.sv
// rtl/fetch_prefetch_queue_pkg.sv - shared FS2DS layout and defaults for the prefetching fetch stage
package fetch_prefetch_queue_pkg;

    localparam int unsigned EXC_W_DEFAULT    = 8;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    // FS2DS bus layout: {exc, inst[31:0], pc[31:0], adef}
    localparam int unsigned FS2DS_ADEF_BIT = 0;
    localparam int unsigned FS2DS_PC_LSB   = 1;
    localparam int unsigned FS2DS_INST_LSB = 33;
    localparam int unsigned FS2DS_EXC_LSB  = 65;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_EX,
        REDIR_ERTN,
        REDIR_BR
    } redir_src_e;

    function automatic int unsigned fs2ds_width(input int unsigned exc_w);
        return exc_w + 65;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - inst_sram, translation and fetch-to-decode signal bundle
interface fetch_prefetch_queue_if
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned EXC_W = EXC_W_DEFAULT
) ();
    localparam int unsigned FS2DS_W = fs2ds_width(EXC_W);

    logic               inst_sram_req;
    logic [31:0]        inst_sram_addr;
    logic               inst_sram_addr_ok;
    logic               inst_sram_data_ok;
    logic [31:0]        inst_sram_rdata;
    logic [31:0]        tr_vaddr;
    logic [31:0]        tr_paddr;
    logic [EXC_W-1:0]   tr_exc;
    logic               ds_allowin;
    logic               fs2ds_valid;
    logic [FS2DS_W-1:0] fs2ds_bus;

    modport master (
        output inst_sram_req, inst_sram_addr, tr_vaddr, fs2ds_valid, fs2ds_bus,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, tr_paddr, tr_exc, ds_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr, tr_vaddr, fs2ds_valid, fs2ds_bus,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, tr_paddr, tr_exc, ds_allowin
    );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// rtl/fetch_prefetch_queue_sync_fifo.sv - synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count < CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - IF stage with multiple outstanding fetches, PC tag FIFO and instruction queue
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUT    = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned EXC_W      = EXC_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    fetch_prefetch_queue_if.master        bus,
    input  logic                          wb_ex,
    input  logic [31:0]                   ex_entry,
    input  logic                          ertn_flush,
    input  logic [31:0]                   ertn_entry,
    input  logic                          br_taken,
    input  logic [31:0]                   br_target,
    input  logic                          br_stall
);
    localparam int unsigned FS2DS_W = fs2ds_width(EXC_W);
    localparam int unsigned QCW     = $clog2(IBUF_DEPTH) + 1;
    localparam int unsigned OCW     = $clog2(MAX_OUT) + 1;

    logic [31:0]        pc;
    logic               halt;
    logic               hold;
    logic [OCW-1:0]     discard_cnt;
    logic [OCW-1:0]     tag_cnt;
    logic [OCW-1:0]     out_cnt;
    logic [QCW-1:0]     q_cnt;
    logic [31:0]        tag_pc;
    redir_src_e         redir_src;
    logic               redirect;
    logic [31:0]        redir_target;
    logic               adef;
    logic               clean;
    logic               room;
    logic               req;
    logic               acc;
    logic               dok;
    logic               fault_push;
    logic               tag_pop;
    logic               q_push;
    logic               q_pop;
    logic [FS2DS_W-1:0] enq_data;
    logic [FS2DS_W-1:0] q_head;

    always_comb begin
        redir_src = REDIR_NONE;
        if (wb_ex)           redir_src = REDIR_EX;
        else if (ertn_flush) redir_src = REDIR_ERTN;
        else if (br_taken)   redir_src = REDIR_BR;
    end

    always_comb begin
        redir_target = br_target;
        case (redir_src)
            REDIR_EX:   redir_target = ex_entry;
            REDIR_ERTN: redir_target = ertn_entry;
            default:    redir_target = br_target;
        endcase
    end

    assign redirect = (redir_src != REDIR_NONE);

    // Tagged requests are live, discarded ones are stale; together they are everything in flight.
    assign out_cnt = tag_cnt + discard_cnt;

    assign adef  = (pc[1:0] != 2'b00);
    assign clean = !adef && (bus.tr_exc == '0);
    assign room  = (32'(out_cnt) < MAX_OUT) && ((32'(q_cnt) + 32'(out_cnt)) < IBUF_DEPTH);

    // A presented but unaccepted request stays up regardless of stall or capacity.
    assign req = !reset && !redirect && (hold || (!halt && !br_stall && room && clean));
    assign acc = req && bus.inst_sram_addr_ok;
    assign dok = bus.inst_sram_data_ok;

    assign fault_push = !reset && !redirect && !halt && !clean &&
                        (out_cnt == '0) && (32'(q_cnt) < IBUF_DEPTH);
    assign tag_pop    = dok && !redirect && (discard_cnt == '0);
    assign q_push     = tag_pop || fault_push;
    assign q_pop      = bus.fs2ds_valid && bus.ds_allowin;

    always_comb begin
        enq_data = '0;
        if (fault_push) begin
            enq_data[FS2DS_EXC_LSB +: EXC_W] = bus.tr_exc;
            enq_data[FS2DS_PC_LSB +: 32]     = pc;
            enq_data[FS2DS_ADEF_BIT]         = adef;
        end else begin
            enq_data[FS2DS_INST_LSB +: 32]   = bus.inst_sram_rdata;
            enq_data[FS2DS_PC_LSB +: 32]     = tag_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            halt        <= 1'b0;
            hold        <= 1'b0;
            discard_cnt <= '0;
        end else if (redirect) begin
            pc          <= redir_target;
            halt        <= 1'b0;
            hold        <= 1'b0;
            // Whatever is still in flight after this edge belongs to the old stream.
            discard_cnt <= out_cnt + OCW'(acc) - OCW'(dok);
        end else begin
            if (acc) pc <= pc + 32'd4;
            hold <= req && !bus.inst_sram_addr_ok;
            if (fault_push) halt <= 1'b1;
            if (dok && (discard_cnt != '0)) discard_cnt <= discard_cnt - OCW'(1);
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (acc),
        .push_data (pc),
        .pop       (tag_pop),
        .pop_data  (tag_pc),
        .count     (tag_cnt)
    );

    sync_fifo #(.WIDTH(FS2DS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (q_push),
        .push_data (enq_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_cnt)
    );

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = bus.tr_paddr;
    assign bus.tr_vaddr       = pc;
    assign bus.fs2ds_valid    = (q_cnt != '0) && !redirect;
    assign bus.fs2ds_bus      = q_head;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench for fetch_prefetch_queue with a latency-programmable bridge
module tb_fetch_prefetch_queue;
    import fetch_prefetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_ex = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0, br_stall = 1'b0;
    logic [31:0] ex_entry = '0, ertn_entry = '0, br_target = '0;

    fetch_prefetch_queue_if #(.EXC_W(8)) bus ();

    fetch_prefetch_queue #(
        .IBUF_DEPTH (4),
        .MAX_OUT    (2),
        .RESET_PC   (32'h1C00_0000),
        .EXC_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .wb_ex      (wb_ex),
        .ex_entry   (ex_entry),
        .ertn_flush (ertn_flush),
        .ertn_entry (ertn_entry),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .br_stall   (br_stall)
    );

    always #5 clk = ~clk;

    int          cyc = 0, lat = 1, hs_cnt = 0, first_hs_cyc = 0;
    logic        accept_en = 1'b1;
    logic [31:0] exc_pc = 32'hFFFF_FFFF;
    logic [7:0]  exc_val = 8'h00;
    logic [31:0] bq_addr[$];
    int          bq_rdy[$];

    logic [31:0] log_pc[$], log_inst[$];
    logic [7:0]  log_exc[$];
    logic        log_adef[$];
    int          log_cyc[$];

    int n_chk = 0, n_pass = 0;

    assign bus.inst_sram_addr_ok = bus.inst_sram_req & accept_en;
    assign bus.tr_paddr          = bus.tr_vaddr;
    assign bus.tr_exc            = (bus.tr_vaddr == exc_pc) ? exc_val : 8'h00;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0000_1234;
    endfunction

    // Bridge: in-order responses, each ready lat cycles after its acceptance.
    always @(negedge clk) begin
        cyc++;
        if (!reset && bq_addr.size() != 0 && bq_rdy[0] <= cyc) begin
            bus.inst_sram_data_ok = 1'b1;
            bus.inst_sram_rdata   = mem_word(bq_addr[0]);
        end else begin
            bus.inst_sram_data_ok = 1'b0;
            bus.inst_sram_rdata   = 32'h0;
        end
        #1;
        if (reset) begin
            bq_addr.delete();
            bq_rdy.delete();
            hs_cnt = 0;
        end else begin
            if (bus.inst_sram_data_ok) begin
                void'(bq_addr.pop_front());
                void'(bq_rdy.pop_front());
            end
            if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
                if (hs_cnt == 0) first_hs_cyc = cyc;
                hs_cnt++;
                bq_addr.push_back(bus.inst_sram_addr);
                bq_rdy.push_back(cyc + lat);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset && bus.fs2ds_valid && bus.ds_allowin) begin
            log_pc.push_back(bus.fs2ds_bus[FS2DS_PC_LSB +: 32]);
            log_inst.push_back(bus.fs2ds_bus[FS2DS_INST_LSB +: 32]);
            log_exc.push_back(bus.fs2ds_bus[FS2DS_EXC_LSB +: 8]);
            log_adef.push_back(bus.fs2ds_bus[FS2DS_ADEF_BIT]);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_entry(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] inst, input logic [7:0] exc, input logic adef);
        if (idx >= log_pc.size()) begin
            check({tag, "_present"}, 64'(log_pc.size()), 64'(idx + 1));
        end else begin
            check({tag, "_pc"}, log_pc[idx], pc);
            check({tag, "_inst"}, log_inst[idx], inst);
            check({tag, "_exc_adef"}, {log_exc[idx], log_adef[idx]}, {exc, adef});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int l, input logic allow);
        reset = 1'b1;
        lat = l;
        bus.ds_allowin = allow;
        wb_ex = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
        exc_pc = 32'hFFFF_FFFF; exc_val = 8'h00;
        tick(2);
        log_pc.delete(); log_inst.delete(); log_exc.delete(); log_adef.delete(); log_cyc.delete();
        reset = 1'b0;
    endtask

    int idx, h0;

    initial begin
        // 1: reset state, then zero-wait streaming
        bus.ds_allowin = 1'b1;
        tick(2);
        #3;
        check("rst_req", bus.inst_sram_req, 1'b0);
        check("rst_valid", bus.fs2ds_valid, 1'b0);
        check("rst_pc", bus.tr_vaddr, 32'h1C00_0000);
        @(negedge clk);
        do_reset(1, 1'b1);
        tick(12);
        check("t1_count", 64'(log_pc.size() >= 8), 1);
        for (int i = 0; i < 8; i++)
            chk_entry($sformatf("t1_e%0d", i), i, 32'h1C00_0000 + 32'(4 * i),
                      mem_word(32'h1C00_0000 + 32'(4 * i)), 8'h00, 1'b0);
        if (log_cyc.size() >= 8) begin
            check("t1_latency", 64'(log_cyc[0] - first_hs_cyc), 2);
            for (int i = 0; i < 7; i++)
                check($sformatf("t1_gap%0d", i), 64'(log_cyc[i + 1] - log_cyc[i]), 1);
        end

        // 2: slow bridge, outstanding limit
        @(negedge clk);
        do_reset(6, 1'b1);
        tick(5);
        #3;
        check("t2_hs", 64'(hs_cnt), 2);
        check("t2_req_blocked", bus.inst_sram_req, 1'b0);
        tick(2);
        #3;
        check("t2_req_resume", bus.inst_sram_req, 1'b1);
        tick(20);
        for (int i = 0; i < 3; i++)
            chk_entry($sformatf("t2_e%0d", i), i, 32'h1C00_0000 + 32'(4 * i),
                      mem_word(32'h1C00_0000 + 32'(4 * i)), 8'h00, 1'b0);

        // 3: decode back-pressure fills the queue, then drains without loss
        @(negedge clk);
        do_reset(1, 1'b0);
        tick(10);
        #3;
        check("t3_hs", 64'(hs_cnt), 4);
        check("t3_req", bus.inst_sram_req, 1'b0);
        check("t3_valid", bus.fs2ds_valid, 1'b1);
        @(negedge clk);
        bus.ds_allowin = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++)
            chk_entry($sformatf("t3_e%0d", i), i, 32'h1C00_0000 + 32'(4 * i),
                      mem_word(32'h1C00_0000 + 32'(4 * i)), 8'h00, 1'b0);

        // 4: branch with two outstanding and a response in the redirect cycle
        @(negedge clk);
        do_reset(3, 1'b1);
        tick(3);
        br_taken = 1'b1; br_target = 32'h1C00_0100;
        #3;
        check("t4_req_redirect", bus.inst_sram_req, 1'b0);
        @(negedge clk);
        br_taken = 1'b0;
        tick(15);
        chk_entry("t4_e0", 0, 32'h1C00_0100, mem_word(32'h1C00_0100), 8'h00, 1'b0);
        chk_entry("t4_e1", 1, 32'h1C00_0104, mem_word(32'h1C00_0104), 8'h00, 1'b0);

        // 5: simultaneous redirects resolve by priority
        @(negedge clk);
        do_reset(1, 1'b1);
        tick(4);
        wb_ex = 1'b1; ex_entry = 32'h1C00_8000;
        ertn_flush = 1'b1; ertn_entry = 32'h1C00_4000;
        br_taken = 1'b1; br_target = 32'h1C00_0100;
        #3;
        check("t5_valid_redirect", bus.fs2ds_valid, 1'b0);
        check("t5_req_redirect", bus.inst_sram_req, 1'b0);
        idx = log_pc.size();
        @(negedge clk);
        wb_ex = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
        #3;
        check("t5_pc", bus.tr_vaddr, 32'h1C00_8000);
        tick(8);
        chk_entry("t5_e0", idx, 32'h1C00_8000, mem_word(32'h1C00_8000), 8'h00, 1'b0);
        chk_entry("t5_e1", idx + 1, 32'h1C00_8004, mem_word(32'h1C00_8004), 8'h00, 1'b0);
        ertn_flush = 1'b1; br_taken = 1'b1;
        idx = log_pc.size();
        @(negedge clk);
        ertn_flush = 1'b0; br_taken = 1'b0;
        tick(8);
        chk_entry("t5_ertn", idx, 32'h1C00_4000, mem_word(32'h1C00_4000), 8'h00, 1'b0);

        // 6: misaligned PC and translation exception each give one entry, then halt
        @(negedge clk);
        do_reset(1, 1'b1);
        tick(3);
        br_taken = 1'b1; br_target = 32'h1C00_0102;
        #3;
        idx = log_pc.size();
        h0 = hs_cnt;
        @(negedge clk);
        br_taken = 1'b0;
        tick(8);
        #3;
        check("t6_adef_count", 64'(log_pc.size()), 64'(idx + 1));
        chk_entry("t6_adef", idx, 32'h1C00_0102, 32'h0, 8'h00, 1'b1);
        check("t6_no_hs", 64'(hs_cnt), 64'(h0));
        check("t6_halt_req", bus.inst_sram_req, 1'b0);
        @(negedge clk);
        exc_pc = 32'h1C00_0200; exc_val = 8'h04;
        br_taken = 1'b1; br_target = 32'h1C00_0200;
        #3;
        idx = log_pc.size();
        @(negedge clk);
        br_taken = 1'b0;
        tick(8);
        #3;
        check("t6_exc_count", 64'(log_pc.size()), 64'(idx + 1));
        chk_entry("t6_exc", idx, 32'h1C00_0200, 32'h0, 8'h04, 1'b0);
        check("t6_exc_halt_req", bus.inst_sram_req, 1'b0);
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h1C00_0300;
        @(negedge clk);
        br_taken = 1'b0;
        tick(6);
        chk_entry("t6_resume", idx + 1, 32'h1C00_0300, mem_word(32'h1C00_0300), 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
